// File: rtl/ram_dma.sv
`default_nettype none
// ============================================================================
//  Module      : ram_dma
//  Description : Bus initiator for a single-port synchronous RAM.
//                LOAD copies a valid/ready byte stream into RAM[base..];
//                DUMP reads RAM[base..] out as a valid/ready stream,
//                hiding the one-cycle read latency with a 2-entry FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_dma #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16384,
   parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     start,
   input  logic                     mode,
   input  logic [ADDRESS_WIDTH-1:0] base,
   input  logic [ADDRESS_WIDTH:0]   len,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   input  logic [DATA_WIDTH-1:0]    s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     ram_we,
   output logic [ADDRESS_WIDTH-1:0] ram_add,
   output logic [DATA_WIDTH-1:0]    ram_din,
   input  logic [DATA_WIDTH-1:0]    ram_dout
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DUMP = 2'd2;

   // Explicit wrap point so a non-power-of-two DEPTH still wraps correctly
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
   localparam logic [ADDRESS_WIDTH-1:0] ONE_ADDR  = 1;
   localparam logic [ADDRESS_WIDTH:0]   ONE_CNT   = 1;

   logic [1:0]               state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [ADDRESS_WIDTH:0]   reads_q, reads_d;   // DUMP reads still to issue
   logic [ADDRESS_WIDTH:0]   beats_q, beats_d;   // transfers still to complete
   logic [DATA_WIDTH-1:0]    fifo0_q, fifo0_d;   // FIFO head
   logic [DATA_WIDTH-1:0]    fifo1_q, fifo1_d;
   logic [1:0]               cnt_q, cnt_d;       // FIFO occupancy 0..2
   logic                     inflight_q, inflight_d;
   logic                     done_q, done_d;
   logic [ADDRESS_WIDTH-1:0] ram_add_q, ram_add_d;

   logic                     in_load;
   logic                     in_dump;
   logic                     wr_fire;
   logic                     rd_fire;
   logic                     pop;
   logic [2:0]               occ;
   logic [1:0]               cnt_after_pop;
   logic [ADDRESS_WIDTH-1:0] addr_inc;

   // Handshake strobes, read-issue decision and the RAM/stream port drive
   always_comb begin
      in_load       = (state_q == ST_LOAD);
      in_dump       = (state_q == ST_DUMP);
      busy          = in_load | in_dump;
      s_ready       = in_load;
      wr_fire       = in_load & s_valid;
      m_valid       = (cnt_q != 2'd0);
      m_data        = fifo0_q;
      done          = done_q;
      pop           = m_valid & m_ready;
      cnt_after_pop = cnt_q - {1'b0, pop};
      // Slots committed after this cycle's pop; a new read needs one free
      occ           = {1'b0, cnt_after_pop} + {2'b00, inflight_q};
      rd_fire       = in_dump & (reads_q != '0) & (occ < 3'd2);
      addr_inc      = (addr_q == LAST_ADDR) ? '0 : addr_q + ONE_ADDR;
      ram_we        = wr_fire;
      ram_din       = s_data;
      // Address only moves when a transfer uses it; otherwise it parks
      ram_add       = (wr_fire | rd_fire) ? addr_q : ram_add_q;
   end

   // Next-state: command acceptance, transfer bookkeeping, FIFO and abort
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      reads_d    = reads_q;
      beats_d    = beats_q;
      fifo0_d    = fifo0_q;
      fifo1_d    = fifo1_q;
      cnt_d      = cnt_q;
      inflight_d = inflight_q;
      done_d     = 1'b0;
      ram_add_d  = ram_add;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = mode ? ST_DUMP : ST_LOAD;
                  addr_d  = base;
                  reads_d = len;
                  beats_d = len;
               end
            end
         end

         ST_LOAD: begin
            if (wr_fire) begin
               addr_d  = addr_inc;
               beats_d = beats_q - ONE_CNT;
               if (beats_q == ONE_CNT) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         ST_DUMP: begin
            if (rd_fire) begin
               addr_d  = addr_inc;
               reads_d = reads_q - ONE_CNT;
            end
            inflight_d = rd_fire;
            if (pop) begin
               fifo0_d = fifo1_q;
            end
            // Returning read data lands in the first free slot after the pop
            if (inflight_q) begin
               if (cnt_after_pop == 2'd0) begin
                  fifo0_d = ram_dout;
               end else begin
                  fifo1_d = ram_dout;
               end
            end
            cnt_d = cnt_after_pop + {1'b0, inflight_q};
            if (pop) begin
               beats_d = beats_q - ONE_CNT;
               if (beats_q == ONE_CNT) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides everything, including a final transfer this cycle
      if (busy && abort) begin
         state_d    = ST_IDLE;
         done_d     = 1'b0;
         cnt_d      = 2'd0;
         inflight_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         reads_q    <= '0;
         beats_q    <= '0;
         fifo0_q    <= '0;
         fifo1_q    <= '0;
         cnt_q      <= 2'd0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         ram_add_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         reads_q    <= reads_d;
         beats_q    <= beats_d;
         fifo0_q    <= fifo0_d;
         fifo1_q    <= fifo1_d;
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
         ram_add_q  <= ram_add_d;
      end
   end

endmodule
`default_nettype wire
